// File: rtl/vend_coin_payer.sv
// vend_coin_payer: customer-side initiator that pays a fixed price in spaced coin pulses to the cola vending FSM
module vend_coin_payer #(
    parameter int PRICE_HALF = 5,
    parameter int COIN_GAP   = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [3:0] wallet_half_in,
    input  logic [3:0] wallet_one_in,
    input  logic       pi_cola,
    input  logic       pi_money,
    output logic       po_money_half,
    output logic       po_money_one,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [5:0] paid_half,
    output logic [3:0] change_half,
    output logic [3:0] half_left,
    output logic [3:0] one_left
);
    localparam int GW = $clog2(COIN_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [5:0]    PRICE    = 6'(PRICE_HALF);
    localparam logic [GW-1:0] GAP_LAST = GW'(COIN_GAP - 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PAY, S_GAP, S_WAIT, S_DONE, S_ERR} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_half_left, r_one_left, r_change;
    logic [5:0]    r_paid;
    logic [1:0]    r_err_code;
    logic          r_got_cola;
    logic [GW-1:0] r_gap;
    logic [TW-1:0] r_timer;
    logic [5:0]    w_total;
    logic          w_paid_ok, w_use_one, w_monitor, w_early;

    assign w_total   = {2'b00, r_half_left} + {1'b0, r_one_left, 1'b0};
    assign w_paid_ok = r_paid >= PRICE;
    // a one-yuan coin is used while it cannot overshoot, or when no half coins remain (overpay)
    assign w_use_one = ((r_paid + 6'd2 <= PRICE) && r_one_left != 4'd0) || r_half_left == 4'd0;
    assign w_monitor = r_state == S_PAY || r_state == S_GAP || r_state == S_WAIT;
    assign w_early   = w_monitor && pi_cola && !w_paid_ok;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = start ? S_CHECK : S_IDLE;
            S_CHECK: w_next = w_total < PRICE ? S_ERR : S_PAY;
            S_PAY:   w_next = w_early ? S_ERR : S_GAP;
            S_GAP:   w_next = w_early ? S_ERR : r_gap != GAP_LAST ? S_GAP : w_paid_ok ? S_WAIT : S_PAY;
            S_WAIT:  w_next = (r_got_cola || pi_cola) ? S_DONE : r_timer == TMO_LAST ? S_ERR : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_half_left <= '0;
            r_one_left  <= '0;
            r_change    <= '0;
            r_paid      <= '0;
            r_err_code  <= '0;
            r_got_cola  <= 1'b0;
            r_gap       <= '0;
            r_timer     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_half_left <= wallet_half_in;
                r_one_left  <= wallet_one_in;
                r_paid      <= '0;
                r_change    <= '0;
                r_err_code  <= '0;
                r_got_cola  <= 1'b0;
            end
            if (r_state == S_PAY) begin
                r_gap   <= '0;
                r_timer <= '0;
                if (w_use_one) begin
                    r_paid     <= r_paid + 6'd2;
                    r_one_left <= r_one_left - 4'd1;
                end else begin
                    r_paid      <= r_paid + 6'd1;
                    r_half_left <= r_half_left - 4'd1;
                end
            end
            if (r_state == S_GAP)
                r_gap <= r_gap + 1'b1;
            if (r_state == S_WAIT)
                r_timer <= r_timer + 1'b1;
            if (w_monitor && pi_money && r_change != 4'hF)
                r_change <= r_change + 4'd1;
            if (w_monitor && pi_cola && w_paid_ok)
                r_got_cola <= 1'b1;
            if (w_next == S_ERR)
                r_err_code <= r_state == S_CHECK ? 2'b01 : r_state == S_WAIT ? 2'b10 : 2'b11;
        end
    end

    assign po_money_one  = r_state == S_PAY && w_use_one;
    assign po_money_half = r_state == S_PAY && !w_use_one;
    assign busy          = r_state != S_IDLE;
    assign done          = r_state == S_DONE;
    assign err           = r_state == S_ERR;
    assign err_code      = r_err_code;
    assign paid_half     = r_paid;
    assign change_half   = r_change;
    assign half_left     = r_half_left;
    assign one_left      = r_one_left;
endmodule

// File: tb/tb_vend_coin_payer.sv
// tb_vend_coin_payer: directed scenarios against the coin payer with a scripted vending partner
module tb_vend_coin_payer;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] wallet_half_in = 4'd0;
    logic [3:0] wallet_one_in = 4'd0;
    logic       pi_cola = 1'b0;
    logic       pi_money = 1'b0;
    logic       po_money_half, po_money_one, busy, done, err;
    logic [1:0] err_code;
    logic [5:0] paid_half;
    logic [3:0] change_half, half_left, one_left;

    int pass_cnt = 0;
    int total_cnt = 0;
    int coin_k[$];
    int coin_one[$];
    int done_k, err_k, both_hi, mpaid;

    vend_coin_payer dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
        .wallet_half_in(wallet_half_in), .wallet_one_in(wallet_one_in),
        .pi_cola(pi_cola), .pi_money(pi_money),
        .po_money_half(po_money_half), .po_money_one(po_money_one),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .paid_half(paid_half), .change_half(change_half),
        .half_left(half_left), .one_left(one_left)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int ck(input int i);
        return i < coin_k.size() ? coin_k[i] : -1;
    endfunction

    function automatic int ct(input int i);
        return i < coin_one.size() ? coin_one[i] : -1;
    endfunction

    function automatic logic [25:0] all_out();
        return {po_money_half, po_money_one, busy, done, err, err_code, paid_half, change_half, half_left, one_left};
    endfunction

    // cola_mode: 0 silent, 1 one cola pulse the cycle after price is reached, 2 cola held from after the first coin
    // money_mode: 0 none, 1 with the cola pulse, 2 held throughout
    task automatic run(input logic [3:0] h, input logic [3:0] o, input int cola_mode,
                       input int money_mode, input bit hold, input int max_k);
        bit pend = 1'b0;
        coin_k.delete();
        coin_one.delete();
        done_k = -1; err_k = -1; both_hi = 0; mpaid = 0;
        @(negedge sys_clk);
        start = 1'b1; wallet_half_in = h; wallet_one_in = o; pi_money = (money_mode == 2);
        for (int k = 1; k <= max_k; k++) begin
            @(negedge sys_clk);
            if (!hold) begin
                start = 1'b0; wallet_half_in = 4'hF; wallet_one_in = 4'hF;
            end
            pi_cola  = pend;
            pi_money = (money_mode == 2) || (money_mode == 1 && pend);
            if (cola_mode != 2) pend = 1'b0;
            if (po_money_half && po_money_one) both_hi++;
            if (po_money_half || po_money_one) begin
                coin_k.push_back(k);
                coin_one.push_back(int'(po_money_one));
                mpaid += po_money_one ? 2 : 1;
                if ((cola_mode == 1 && mpaid >= 5) || cola_mode == 2) pend = 1'b1;
            end
            if (done) begin done_k = k; break; end
            if (err) begin err_k = k; break; end
        end
        pi_cola = 1'b0; pi_money = 1'b0;
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        total_cnt++; if (all_out() !== 26'd0) $display("FAIL reset_outputs got %h exp 0", all_out()); else pass_cnt++;
        @(negedge sys_clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_exact_pay();
        run(4'd1, 4'd2, 1, 0, 1'b0, 40);
        total_cnt++; if (done_k !== 15) $display("FAIL exact_done_cycle got %0d exp 15", done_k); else pass_cnt++;
        total_cnt++; if ({ck(0), ck(1), ck(2), ck(3)} !== {32'd2, 32'd6, 32'd10, -32'sd1}) $display("FAIL exact_coin_times got %0d %0d %0d %0d exp 2 6 10 -1", ck(0), ck(1), ck(2), ck(3)); else pass_cnt++;
        total_cnt++; if ({ct(0), ct(1), ct(2)} !== {32'd1, 32'd1, 32'd0}) $display("FAIL exact_coin_kinds got %0d %0d %0d exp 1 1 0", ct(0), ct(1), ct(2)); else pass_cnt++;
        total_cnt++; if (both_hi !== 0) $display("FAIL exact_both_coins got %0d exp 0", both_hi); else pass_cnt++;
        total_cnt++; if ({paid_half, change_half, half_left, one_left} !== {6'd5, 4'd0, 4'd0, 4'd0}) $display("FAIL exact_counters got paid=%0d chg=%0d h=%0d o=%0d exp 5 0 0 0", paid_half, change_half, half_left, one_left); else pass_cnt++;
        @(negedge sys_clk);
        total_cnt++; if ({done, busy} !== 2'b00) $display("FAIL exact_after_done got done=%b busy=%b exp 0 0", done, busy); else pass_cnt++;
        total_cnt++; if (paid_half !== 6'd5) $display("FAIL exact_paid_hold got %0d exp 5", paid_half); else pass_cnt++;
    endtask

    task automatic test_overpay();
        run(4'd0, 4'd3, 1, 1, 1'b0, 40);
        total_cnt++; if (done_k !== 15) $display("FAIL overpay_done_cycle got %0d exp 15", done_k); else pass_cnt++;
        total_cnt++; if ({ct(0), ct(1), ct(2), ck(3)} !== {32'd1, 32'd1, 32'd1, -32'sd1}) $display("FAIL overpay_coin_kinds got %0d %0d %0d next=%0d exp 1 1 1 -1", ct(0), ct(1), ct(2), ck(3)); else pass_cnt++;
        total_cnt++; if ({paid_half, change_half, one_left} !== {6'd6, 4'd1, 4'd0}) $display("FAIL overpay_counters got paid=%0d chg=%0d o=%0d exp 6 1 0", paid_half, change_half, one_left); else pass_cnt++;
    endtask

    task automatic test_insufficient();
        run(4'd1, 4'd1, 0, 0, 1'b0, 20);
        total_cnt++; if (err_k !== 2) $display("FAIL funds_err_cycle got %0d exp 2", err_k); else pass_cnt++;
        total_cnt++; if (err_code !== 2'b01) $display("FAIL funds_err_code got %b exp 01", err_code); else pass_cnt++;
        total_cnt++; if (coin_k.size() !== 0) $display("FAIL funds_no_coins got %0d exp 0", coin_k.size()); else pass_cnt++;
        @(negedge sys_clk);
        total_cnt++; if ({busy, err, err_code} !== 4'b0001) $display("FAIL funds_after got busy=%b err=%b code=%b exp 0 0 01", busy, err, err_code); else pass_cnt++;
    endtask

    task automatic test_timeout();
        run(4'd5, 4'd0, 0, 0, 1'b0, 60);
        total_cnt++; if ({ck(0), ck(1), ck(2), ck(3), ck(4)} !== {32'd2, 32'd6, 32'd10, 32'd14, 32'd18}) $display("FAIL timeout_coin_times got %0d %0d %0d %0d %0d exp 2 6 10 14 18", ck(0), ck(1), ck(2), ck(3), ck(4)); else pass_cnt++;
        total_cnt++; if ({ct(0), ct(1), ct(2), ct(3), ct(4)} !== 160'd0) $display("FAIL timeout_coin_kinds got %0d %0d %0d %0d %0d exp all 0", ct(0), ct(1), ct(2), ct(3), ct(4)); else pass_cnt++;
        total_cnt++; if (err_k !== 38) $display("FAIL timeout_err_cycle got %0d exp 38", err_k); else pass_cnt++;
        total_cnt++; if ({err_code, paid_half, half_left} !== {2'b10, 6'd5, 4'd0}) $display("FAIL timeout_state got code=%b paid=%0d h=%0d exp 10 5 0", err_code, paid_half, half_left); else pass_cnt++;
    endtask

    task automatic test_early_cola();
        run(4'd1, 4'd2, 2, 0, 1'b0, 30);
        total_cnt++; if (err_k !== 4) $display("FAIL early_err_cycle got %0d exp 4", err_k); else pass_cnt++;
        total_cnt++; if (err_code !== 2'b11) $display("FAIL early_err_code got %b exp 11", err_code); else pass_cnt++;
        total_cnt++; if (coin_k.size() !== 1) $display("FAIL early_coin_count got %0d exp 1", coin_k.size()); else pass_cnt++;
        total_cnt++; if ({paid_half, half_left, one_left} !== {6'd2, 4'd1, 4'd1}) $display("FAIL early_counters got paid=%0d h=%0d o=%0d exp 2 1 1", paid_half, half_left, one_left); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        run(4'd1, 4'd2, 0, 0, 1'b0, 7);
        total_cnt++; if ({coin_k.size(), busy} !== {32'd2, 1'b1}) $display("FAIL midrst_before got coins=%0d busy=%b exp 2 1", coin_k.size(), busy); else pass_cnt++;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        total_cnt++; if (all_out() !== 26'd0) $display("FAIL midrst_outputs got %h exp 0", all_out()); else pass_cnt++;
        run(4'd1, 4'd2, 1, 0, 1'b0, 40);
        total_cnt++; if ({done_k, paid_half, half_left, one_left} !== {32'd15, 6'd5, 4'd0, 4'd0}) $display("FAIL midrst_fresh got done_k=%0d paid=%0d h=%0d o=%0d exp 15 5 0 0", done_k, paid_half, half_left, one_left); else pass_cnt++;
    endtask

    task automatic test_change_sat();
        run(4'd0, 4'd3, 0, 2, 1'b0, 60);
        total_cnt++; if (err_k !== 30) $display("FAIL sat_err_cycle got %0d exp 30", err_k); else pass_cnt++;
        total_cnt++; if ({change_half, err_code} !== {4'd15, 2'b10}) $display("FAIL sat_change got chg=%0d code=%b exp 15 10", change_half, err_code); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run(4'd1, 4'd1, 0, 0, 1'b1, 20);
        total_cnt++; if (err_k !== 2) $display("FAIL b2b_first_err got %0d exp 2", err_k); else pass_cnt++;
        @(negedge sys_clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle_gap got busy=%b exp 0", busy); else pass_cnt++;
        @(negedge sys_clk);
        total_cnt++; if ({busy, half_left, one_left} !== {1'b1, 4'd1, 4'd1}) $display("FAIL b2b_restart got busy=%b h=%0d o=%0d exp 1 1 1", busy, half_left, one_left); else pass_cnt++;
        @(negedge sys_clk);
        total_cnt++; if ({err, err_code} !== 3'b101) $display("FAIL b2b_second_err got err=%b code=%b exp 1 01", err, err_code); else pass_cnt++;
        start = 1'b0;
        @(negedge sys_clk);
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_overpay();
        test_insufficient();
        test_timeout();
        test_early_cola();
        test_reset_mid();
        test_change_sat();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/vend_coin_payer.md
Name: vend_coin_payer

Overview:
- Customer-side initiator for the cola vending FSM: drives its coin inputs (half-yuan / one-yuan pulses) and consumes its cola and change outputs.
- Loads a wallet, pays a fixed price as a spaced sequence of one-cycle coin pulses, then waits for cola.
- Counts returned change and reports done or error.
- Used as a closed-loop stimulus/partner block for the vending FSM in system sims and on-board demos.

Parameters:
PRICE_HALF, 5, price in half-yuan units (5 = 2.5 yuan); legal 1..31
COIN_GAP, 4, cycles from one coin pulse to the next; legal >= 2
TIMEOUT, 16, max cycles in WAIT_COLA before error; legal >= 2

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  synchronous active-low reset
start  input  1  request purchase; sampled only in IDLE
wallet_half_in  input  4  half-yuan coins available, latched on accepted start
wallet_one_in  input  4  one-yuan coins available, latched on accepted start
pi_cola  input  1  cola pulse from vending FSM
pi_money  input  1  change pulse from vending FSM (one half-yuan each)
po_money_half  output  1  one-cycle half-yuan coin pulse to vending FSM
po_money_one  output  1  one-cycle one-yuan coin pulse to vending FSM
busy  output  1  high from accepted start until DONE/ERR exit
done  output  1  one-cycle success pulse
err  output  1  one-cycle error pulse
err_code  output  2  01 insufficient funds, 10 timeout, 11 early cola; held until next accepted start
paid_half  output  6  half-yuan units paid this purchase
change_half  output  4  change pulses counted this purchase (saturates at 15)
half_left  output  4  remaining half coins
one_left  output  4  remaining one coins

Behaviour:
- Reset (sync, sys_rst_n=0 at an edge): state IDLE. All outputs 0 (including err_code and counters). A coin pulse in flight drops at that edge. No partial purchase survives.
- States: IDLE, CHECK, PAY, GAP, WAIT_COLA, DONE, ERR.
- IDLE:
  - start=1 latches wallet into half_left/one_left.
  - Clears paid_half, change_half, err_code.
  - Sets busy; next state CHECK.
  - start is ignored in all other states.
- CHECK (1 cycle):
  - total = half_left + 2*one_left, 6-bit.
  - total < PRICE_HALF -> ERR with err_code=01; no coin is ever pulsed.
  - Otherwise -> PAY.
- PAY (1 cycle), coin choice with rem = PRICE_HALF - paid_half:
  - rem >= 2 and one_left > 0: pulse po_money_one; paid += 2; one_left -= 1.
  - Else if half_left > 0: pulse po_money_half; paid += 1; half_left -= 1.
  - Else: pulse po_money_one; paid += 2; one_left -= 1 (overpay; change expected).
  - Exactly one coin output is high in the PAY cycle; both are 0 in every other state.
- GAP: hold for COIN_GAP-1 cycles.
  - On exit, if paid_half >= PRICE_HALF -> WAIT_COLA (timer cleared); else -> PAY.
  - Coin pulse period is therefore exactly COIN_GAP cycles.
- Monitoring in PAY/GAP/WAIT_COLA:
  - Every pi_money=1 cycle increments change_half (saturating).
  - pi_cola=1 while paid_half < PRICE_HALF -> ERR with err_code=11.
  - pi_cola=1 once paid_half >= PRICE_HALF (including during the last GAP) sets an internal got_cola flag.
- WAIT_COLA:
  - got_cola already set, or pi_cola this cycle -> DONE.
  - Otherwise timer increments; timer reaching TIMEOUT -> ERR with err_code=10.
  - Change pulses coincident with cola are counted.
- DONE (1 cycle): done=1, busy=0 next cycle, -> IDLE. paid_half/change_half/*_left hold until next accepted start.
- ERR (1 cycle): err=1, -> IDLE. Counters hold their values at the error point.
- Simultaneous events:
  - pi_cola and pi_money in the same cycle: both are recorded.
  - start asserted during busy: ignored, with no queuing.
  - start held high continuously: a new purchase begins in the IDLE cycle after DONE/ERR.

Test Plan:
- Wallet half=1, one=2, PRICE 5: coins one@t, one@t+4, half@t+8; partner answers cola -> done=1, paid_half=5, change_half=0, half_left=0, one_left=0.
- Wallet half=0, one=3: three one-coin pulses, paid_half=6; partner returns cola+money -> done, change_half=1, one_left=0.
- Wallet half=1, one=1 (total 3 < 5): err=1, err_code=01 two cycles after start; po_money_* never high; busy low afterward.
- Wallet half=5, one=0, partner silent: five half pulses spaced 4 cycles; err_code=10 exactly TIMEOUT=16 cycles after entering WAIT_COLA.
- pi_cola forced high after the first coin (paid_half=2): err_code=11; no further coin pulses.
- sys_rst_n low for 1 cycle during GAP after the second coin: all outputs 0 next cycle, state IDLE; a fresh start with half=1, one=2 completes normally.
